// File: rtl/cpu_mult_pkg.sv
// Shared constants and helpers for the limb-based pipelined multiplier.
package cpu_mult_pkg;

   localparam int LIMB_W     = 16;
   localparam int DATA_W_MIN = 16;
   localparam int DATA_W_MAX = 64;
   localparam int STAGES_MIN = 1;
   localparam int STAGES_MAX = 3;

   function automatic int num_limbs(input int data_w);
      return data_w / LIMB_W;
   endfunction

endpackage

// File: rtl/cpu_mult_limb.sv
// 16x16 unsigned limb multiplier; registered with clock enable and async clear,
// or a pure combinational product when REGISTERED=0 (single-stage pipeline).
module cpu_mult_limb
   import cpu_mult_pkg::*;
#(
   parameter bit REGISTERED = 1'b1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                en,
   input  logic [LIMB_W-1:0]   a,
   input  logic [LIMB_W-1:0]   b,
   output logic [2*LIMB_W-1:0] p
);

   logic [2*LIMB_W-1:0] prod;

   assign prod = {{LIMB_W{1'b0}}, a} * {{LIMB_W{1'b0}}, b};

   if (REGISTERED) begin : g_reg
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            p <= '0;
         end else if (en) begin
            p <= prod;
         end
      end
   end else begin : g_comb
      logic unused_ctl;
      assign unused_ctl = clk ^ reset_n ^ en;
      assign p = prod;
   end

endmodule

// File: rtl/cpu_mult_pipe.sv
// Pipelined DATA_W x DATA_W multiplier built from 16x16 limb products.
// Define CPU_MULT_PIPE_HI_EN for signed operands and upper-half (in_hi) results.
module cpu_mult_pipe
   import cpu_mult_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_src1,
   input  logic [DATA_W-1:0] in_src2,
   input  logic              in_sign1,
   input  logic              in_sign2,
   input  logic              in_hi,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_result
);

   localparam int NL  = num_limbs(DATA_W);
   localparam int NPP = NL * NL;
   localparam int PW  = 2 * DATA_W;

   if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX || (DATA_W % LIMB_W) != 0 ||
       STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_cfg
      $error("cpu_mult_pipe: unsupported DATA_W/STAGES combination");
   end

   function automatic logic [DATA_W-1:0] select_half(input logic [PW-1:0] p, input logic hi);
      return hi ? p[PW-1:DATA_W] : p[DATA_W-1:0];
   endfunction

   logic              hi_in;
   logic              neg1;
   logic              neg2;
   logic [DATA_W-1:0] corr_in;

`ifdef CPU_MULT_PIPE_HI_EN
   localparam bit HI_EN = 1'b1;
   assign hi_in = in_hi;
   assign neg1  = in_sign1 & in_src1[DATA_W-1];
   assign neg2  = in_sign2 & in_src2[DATA_W-1];
`else
   localparam bit HI_EN = 1'b0;
   logic unused_cfg;
   assign unused_cfg = in_hi ^ in_sign1 ^ in_sign2;
   assign hi_in = 1'b0;
   assign neg1  = 1'b0;
   assign neg2  = 1'b0;
`endif

   // A negative operand is its raw value minus 2^DATA_W, so the signed product
   // is the unsigned one minus the other operand shifted into the upper half.
   assign corr_in = (neg1 ? in_src2 : '0) + (neg2 ? in_src1 : '0);

   assign in_ready = en;

   logic [2*LIMB_W-1:0] pp [NPP];
   logic                vld_c;
   logic                hi_c;
   logic [DATA_W-1:0]   corr_c;

   for (genvar i = 0; i < NL; i++) begin : g_row
      for (genvar j = 0; j < NL; j++) begin : g_col
         if (HI_EN || (i + j < NL)) begin : g_mul
            cpu_mult_limb #(.REGISTERED(STAGES > 1)) u_limb (
               .clk     (clk),
               .reset_n (reset_n),
               .en      (en),
               .a       (in_src1[i*LIMB_W +: LIMB_W]),
               .b       (in_src2[j*LIMB_W +: LIMB_W]),
               .p       (pp[i*NL+j])
            );
         end else begin : g_none
            assign pp[i*NL+j] = '0;
         end
      end
   end

   // Stage 1: limb products (inside the limbs) plus carried control
   if (STAGES == 1) begin : g_s1_comb
      assign vld_c  = in_valid;
      assign hi_c   = hi_in;
      assign corr_c = corr_in;
   end else begin : g_s1_reg
      logic              vld_p0;
      logic              hi_p0;
      logic [DATA_W-1:0] corr_p0;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            vld_p0  <= 1'b0;
            hi_p0   <= 1'b0;
            corr_p0 <= '0;
         end else begin
            if (flush) begin
               vld_p0 <= 1'b0;
            end else if (en) begin
               vld_p0 <= in_valid;
            end
            if (en) begin
               hi_p0   <= hi_in;
               corr_p0 <= corr_in;
            end
         end
      end

      assign vld_c  = vld_p0;
      assign hi_c   = hi_p0;
      assign corr_c = corr_p0;
   end

   logic [PW-1:0] sum_a;
   logic [PW-1:0] sum_b;

   always_comb begin
      sum_a = '0;
      sum_b = '0;
      for (int k = 0; k < NPP; k++) begin
         if (k < NPP / 2) begin
            sum_a = sum_a + (PW'(pp[k]) << (LIMB_W * (k / NL + k % NL)));
         end else begin
            sum_b = sum_b + (PW'(pp[k]) << (LIMB_W * (k / NL + k % NL)));
         end
      end
      sum_b = sum_b - {corr_c, {DATA_W{1'b0}}};
   end

   logic          vld_l;
   logic          hi_l;
   logic [PW-1:0] total;

   // Stage 2 (three-stage build only): two half-sums of the partial products
   if (STAGES == 3) begin : g_s2_reg
      logic          vld_p1;
      logic          hi_p1;
      logic [PW-1:0] sum_a_p1;
      logic [PW-1:0] sum_b_p1;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            vld_p1   <= 1'b0;
            hi_p1    <= 1'b0;
            sum_a_p1 <= '0;
            sum_b_p1 <= '0;
         end else begin
            if (flush) begin
               vld_p1 <= 1'b0;
            end else if (en) begin
               vld_p1 <= vld_c;
            end
            if (en) begin
               hi_p1    <= hi_c;
               sum_a_p1 <= sum_a;
               sum_b_p1 <= sum_b;
            end
         end
      end

      assign vld_l = vld_p1;
      assign hi_l  = hi_p1;
      assign total = sum_a_p1 + sum_b_p1;
   end else begin : g_s2_comb
      assign vld_l = vld_c;
      assign hi_l  = hi_c;
      assign total = sum_a + sum_b;
   end

   // Final stage: result register only loads on a live operation, so bubbles hold it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (en) begin
            out_valid <= vld_l;
         end
         if (en && vld_l && !flush) begin
            out_result <= select_half(total, hi_l);
         end
      end
   end

endmodule

// File: tb/tb_cpu_mult_pipe.sv
// Bench: 16/1, 32/2 and 64/3 pipelines driven in lockstep, checked against a
// latency-queue model whose results come from wide signed integer arithmetic.
module tb_cpu_mult_pipe;

   localparam int NDUT = 3;
   localparam int W_TAB [NDUT] = '{16, 32, 64};
   localparam int S_TAB [NDUT] = '{1, 2, 3};
`ifdef CPU_MULT_PIPE_HI_EN
   localparam bit HI_MODE = 1'b1;
`else
   localparam bit HI_MODE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n, en, flush, in_valid, sign1, sign2, hi;
   logic [63:0] src1, src2;
   logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
   logic [15:0] r16;
   logic [31:0] r32;
   logic [63:0] r64;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cpu_mult_pipe #(.DATA_W(16), .STAGES(1)) u_d16 (
      .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .in_valid(in_valid),
      .in_ready(rdy0), .in_src1(src1[15:0]), .in_src2(src2[15:0]), .in_sign1(sign1),
      .in_sign2(sign2), .in_hi(hi), .out_valid(ov0), .out_result(r16));

   cpu_mult_pipe #(.DATA_W(32), .STAGES(2)) u_d32 (
      .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .in_valid(in_valid),
      .in_ready(rdy1), .in_src1(src1[31:0]), .in_src2(src2[31:0]), .in_sign1(sign1),
      .in_sign2(sign2), .in_hi(hi), .out_valid(ov1), .out_result(r32));

   cpu_mult_pipe #(.DATA_W(64), .STAGES(3)) u_d64 (
      .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .in_valid(in_valid),
      .in_ready(rdy2), .in_src1(src1), .in_src2(src2), .in_sign1(sign1),
      .in_sign2(sign2), .in_hi(hi), .out_valid(ov2), .out_result(r64));

   typedef struct packed {
      logic        v;
      logic [63:0] r;
   } slot_t;

   typedef struct packed {
      logic [63:0] a;
      logic [63:0] b;
      logic        s1;
      logic        s2;
      logic        h;
      logic [31:0] e_hi;
      logic [31:0] e_lo;
   } vec_t;

   slot_t       hist [NDUT][$];
   logic        exp_v [NDUT];
   logic [63:0] exp_r [NDUT];
   vec_t        vec [11];

   function automatic logic [63:0] ref_mult(input int w, input logic [63:0] a, input logic [63:0] b,
                                            input logic s1, input logic s2, input logic h);
      logic [63:0]         mask;
      logic signed [131:0] ea, eb, p;
      logic [131:0]        sel;
      mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      ea = $signed({68'd0, a & mask});
      eb = $signed({68'd0, b & mask});
      if (HI_MODE && s1 && a[w-1]) ea = ea - (132'sd1 <<< w);
      if (HI_MODE && s2 && b[w-1]) eb = eb - (132'sd1 <<< w);
      p   = ea * eb;
      sel = (HI_MODE && h) ? (p >> w) : p;
      return sel[63:0] & mask;
   endfunction

   function automatic logic dut_ov(input int d);
      case (d)
         0:       return ov0;
         1:       return ov1;
         default: return ov2;
      endcase
   endfunction

   function automatic logic dut_rdy(input int d);
      case (d)
         0:       return rdy0;
         1:       return rdy1;
         default: return rdy2;
      endcase
   endfunction

   function automatic logic [63:0] dut_res(input int d);
      case (d)
         0:       return {48'd0, r16};
         1:       return {32'd0, r32};
         default: return r64;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < NDUT; d++) begin
         hist[d].delete();
         for (int k = 0; k < S_TAB[d] - 1; k++) hist[d].push_back({1'b0, 64'd0});
         exp_v[d] = 1'b0;
         exp_r[d] = '0;
      end
   endtask

   task automatic model_update();
      slot_t s;
      for (int d = 0; d < NDUT; d++) begin
         if (flush) begin
            for (int k = 0; k < hist[d].size(); k++) begin
               s = hist[d][k];
               s.v = 1'b0;
               hist[d][k] = s;
            end
            exp_v[d] = 1'b0;
            if (en) begin
               hist[d].push_back({1'b0, 64'd0});
               void'(hist[d].pop_front());
            end
         end else if (en) begin
            s.v = in_valid;
            s.r = ref_mult(W_TAB[d], src1, src2, sign1, sign2, hi);
            hist[d].push_back(s);
            s = hist[d].pop_front();
            exp_v[d] = s.v;
            if (s.v) exp_r[d] = s.r;
         end
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < NDUT; d++) begin
         check($sformatf("w%0d_out_valid", W_TAB[d]), {63'd0, dut_ov(d)}, {63'd0, exp_v[d]});
         check($sformatf("w%0d_out_result", W_TAB[d]), dut_res(d), exp_r[d]);
         check($sformatf("w%0d_in_ready", W_TAB[d]), {63'd0, dut_rdy(d)}, {63'd0, en});
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
   endtask

   task automatic set_op(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic s1, input logic s2, input logic h);
      in_valid = v;
      src1     = a;
      src2     = b;
      sign1    = s1;
      sign2    = s2;
      hi       = h;
   endtask

   function automatic logic [63:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return {64{1'b1}};
         1:       return 64'h8000_0000_8000_8000;
         2:       return 64'd0;
         3:       return {32'd0, $urandom};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      logic [63:0] e0, e1, e2;

      vec[0]  = '{64'h0000FFFF, 64'h0000FFFF, 1'b0, 1'b0, 1'b0, 32'hFFFE0001, 32'hFFFE0001};
      vec[1]  = '{64'hFFFFFFFF, 64'h00000002, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE};
      vec[2]  = '{64'hFFFFFFFF, 64'h00000002, 1'b0, 1'b0, 1'b1, 32'h00000001, 32'hFFFFFFFE};
      vec[3]  = '{64'h00010000, 64'h00010000, 1'b0, 1'b0, 1'b1, 32'h00000001, 32'h00000000};
      vec[4]  = '{64'h80000000, 64'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000, 32'h00000000};
      vec[5]  = '{64'h80000000, 64'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h80000000, 32'h80000000};
      vec[6]  = '{64'h7FFFFFFF, 64'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 32'h3FFFFFFF, 32'h00000001};
      vec[7]  = '{64'h00000003, 64'h00000005, 1'b1, 1'b1, 1'b0, 32'h0000000F, 32'h0000000F};
      vec[8]  = '{64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001};
      vec[9]  = '{64'hFFFFFFFF, 64'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFE, 32'h00000001};
      vec[10] = '{64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'h00000000, 32'h00000001};

      reset_n = 1'b0;
      en      = 1'b0;
      flush   = 1'b0;
      set_op(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(negedge clk);
      check_all();

      reset_n = 1'b1;
      en      = 1'b1;

      // Directed table on the 32-bit, two-stage instance
      for (int i = 0; i < 11; i++) begin
         set_op(1'b1, vec[i].a, vec[i].b, vec[i].s1, vec[i].s2, vec[i].h);
         cycle();
         in_valid = 1'b0;
         cycle();
         check($sformatf("vec32_%0d", i), {32'd0, r32},
               {32'd0, HI_MODE ? vec[i].e_hi : vec[i].e_lo});
         cycle();
      end

      // 64-bit limb boundary: 2^32 * 2^32
      set_op(1'b1, 64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 1'b0, 1'b1);
      cycle();
      in_valid = 1'b0;
      repeat (2) cycle();
      check("w64_limb_boundary", r64, HI_MODE ? 64'd1 : 64'd0);
      check("w64_limb_boundary_valid", {63'd0, ov2}, 64'd1);

      // Back-to-back issues, stall three cycles, then drain in order
      e0 = 0; e1 = 0; e2 = 0;
      for (int k = 0; k < 3; k++) begin
         set_op(1'b1, rand_op(), rand_op(), 1'($urandom), 1'($urandom), 1'($urandom));
         case (k)
            0:       e0 = ref_mult(64, src1, src2, sign1, sign2, hi);
            1:       e1 = ref_mult(64, src1, src2, sign1, sign2, hi);
            default: e2 = ref_mult(64, src1, src2, sign1, sign2, hi);
         endcase
         cycle();
      end
      check("b2b_first", r64, e0);
      en = 1'b0;
      set_op(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("stall_frozen_result", r64, e0);
         check("stall_frozen_valid", {63'd0, ov2}, 64'd1);
      end
      en = 1'b1;
      in_valid = 1'b0;
      cycle();
      check("b2b_second", r64, e1);
      cycle();
      check("b2b_third", r64, e2);
      cycle();

      // Flush together with a valid issue while operations are in flight
      set_op(1'b1, rand_op(), rand_op(), 1'b0, 1'b0, 1'b0);
      cycle();
      set_op(1'b1, rand_op(), rand_op(), 1'b1, 1'b1, 1'b1);
      cycle();
      flush = 1'b1;
      set_op(1'b1, 64'd7, 64'd9, 1'b0, 1'b0, 1'b0);
      cycle();
      flush = 1'b0;
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("flush_w32_valid", {63'd0, ov1}, 64'd0);
         check("flush_w64_valid", {63'd0, ov2}, 64'd0);
         cycle();
      end

      // Asynchronous reset mid-flight
      set_op(1'b1, rand_op(), rand_op(), 1'b0, 1'b0, 1'b1);
      cycle();
      set_op(1'b1, rand_op(), rand_op(), 1'b1, 1'b0, 1'b0);
      cycle();
      reset_n = 1'b0;
      #1;
      check("rst_w16_valid", {63'd0, ov0}, 64'd0);
      check("rst_w32_valid", {63'd0, ov1}, 64'd0);
      check("rst_w64_valid", {63'd0, ov2}, 64'd0);
      check("rst_w32_result", {32'd0, r32}, 64'd0);
      check("rst_w64_result", r64, 64'd0);
      model_reset();
      in_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("post_rst_no_stale", {63'd0, ov2 | ov1 | ov0}, 64'd0);
      end

      // Randomized traffic with stalls, bubbles and occasional flushes
      for (int k = 0; k < 400; k++) begin
         en    = ($urandom_range(0, 7) != 0);
         flush = ($urandom_range(0, 24) == 0);
         set_op(($urandom_range(0, 3) != 0), rand_op(), rand_op(),
                1'($urandom), 1'($urandom), 1'($urandom));
         cycle();
      end
      en    = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      repeat (4) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_mult_pipe.md
CPU_MULT_PIPE -- requirements
Module: cpu_mult_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; legal values are 16, 32 and 64 (multiple of 16).
REQ-002 SHALL have parameter STAGES, default 2, issue-to-result latency in cycles; legal values are 1 to 3.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1 bit: pipeline advance enable; low stalls every stage.
REQ-006 SHALL have port flush, input, 1 bit: synchronous kill of all in-flight operations.
REQ-007 SHALL have port in_valid, input, 1 bit: the operation on the in_* ports is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: equals en, combinational.
REQ-009 SHALL have ports in_src1 and in_src2, input, DATA_W bits each: the operands.
REQ-010 SHALL have ports in_sign1 and in_sign2, input, 1 bit each: 1 means the corresponding operand is two's-complement.
REQ-011 SHALL have port in_hi, input, 1 bit: select the upper half of the product.
REQ-012 SHALL have port out_valid, output, 1 bit: out_result holds a completed operation.
REQ-013 SHALL have port out_result, output, DATA_W bits: the selected product half.

Function
REQ-014 SHALL form the product P = ext(in_src1) * ext(in_src2), 2*DATA_W bits wide; ext() sign-extends by one bit when the operand's sign flag is 1 and zero-extends otherwise.
REQ-015 SHALL drive out_result as P[2*DATA_W-1:DATA_W] when in_hi=1, else P[DATA_W-1:0]; in_hi is carried with the operation.
REQ-016 SHALL split each operand into 16-bit limbs and form every limb-by-limb partial product; the sign correction is applied on the most-significant limbs only.
REQ-017 SHALL register the partial products in stage 1 and reduce them in the remaining STAGES-1 adder stages; with STAGES=1 the partial products and the sum are computed combinationally into one register.
REQ-018 SHALL accept an operation on every edge where en=1 and in_valid=1, and present it STAGES enabled edges later with out_valid=1.
REQ-019 SHALL allow back-to-back issue: throughput is one operation per enabled cycle.
REQ-020 SHALL hold every stage register, every valid bit, out_valid and out_result unchanged on an edge where en=0.
REQ-021 SHALL clear all stage valid bits on an edge where flush=1, regardless of en and in_valid; data registers may keep stale values.
REQ-022 SHALL give flush priority over a same-cycle issue: the new operation is discarded.
REQ-023 SHALL load a bubble (valid bit 0) on an enabled edge with in_valid=0; out_result then holds its previous value.

Reset
REQ-024 SHALL, while reset_n=0, asynchronously force all valid bits and out_valid to 0 and out_result and all stage data to 0.
REQ-025 SHALL discard any operation in flight at reset; the first result after deassertion appears STAGES enabled edges after the first post-reset issue.

Configuration
REQ-026 SHALL, with CPU_MULT_PIPE_HI_EN defined, implement all limb products and honour in_hi per REQ-015.
REQ-027 SHALL, without CPU_MULT_PIPE_HI_EN, omit the limb products that contribute only to P[2*DATA_W-1:DATA_W], ignore in_hi and the sign flags, and always return P[DATA_W-1:0].

Structure
REQ-028 SHALL take LIMB_W=16, the legal DATA_W and STAGES ranges, and the limb-count function from the shared package cpu_mult_pkg.
REQ-029 SHALL use one sub-module, cpu_mult_limb, a registered 16x16 unsigned multiplier with clock enable and asynchronous clear, instantiated once per limb pair.

Verification
REQ-030 SHALL be verified with: DATA_W=32, STAGES=2, 0x0000FFFF*0x0000FFFF, unsigned, lo -> out_result=0xFFFE0001 two edges later.
REQ-031 SHALL be verified with: 0xFFFFFFFF*0x00000002, sign1=1, sign2=1, hi -> 0xFFFFFFFF; the same operands with sign1=0, sign2=0, hi -> 0x00000001.
REQ-032 SHALL be verified with: three back-to-back issues followed by en=0 for 3 cycles -> outputs frozen, then the three results appear in order on consecutive edges.
REQ-033 SHALL be verified with: flush=1 asserted together with a valid issue while two operations are in flight -> out_valid stays 0 for the next STAGES edges.
REQ-034 SHALL be verified with: reset_n pulsed low mid-flight -> out_valid=0 and out_result=0 immediately, with no stale result afterwards.
REQ-035 SHALL be verified with: DATA_W=64 and macro undefined, 0x100000000*0x100000000, in_hi=1 -> out_result=0 (low word) after STAGES edges.
